target_centroid_tracker: RTL and testbench

- Per-frame object locator feeding the trajectory overlay stage.
- Scans every valid pixel of a frame and flags pixels whose colour lies inside a red target window.
- Accumulates matched coordinates; at end of frame it divides them into a centroid.
- Emits the top-left corner of the tracking sub-frame as o_pointH/o_pointV with a one-cycle o_pointVAL pulse.

---
 rtl/tracking_pkg.sv | 27 ++
 rtl/seq_divider.sv | 81 ++++++++
 rtl/target_centroid_tracker.sv | 185 ++++++++++++++++++
 tb/tb_target_centroid_tracker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tracking_pkg.sv
// Shared constants, widths and FSM state type for the target centroid tracker.
package tracking_pkg;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int SUB_H   = 64;
  localparam int SUB_V   = 48;

  localparam int R_MSB = 29;
  localparam int R_LSB = 20;
  localparam int G_MSB = 19;
  localparam int G_LSB = 10;
  localparam int B_MSB = 9;
  localparam int B_LSB = 0;

  localparam int SUM_W   = 28;
  localparam int CNT_W   = 19;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV_H = 2'd1,
    DIV_V = 2'd2,
    OUT   = 2'd3
  } track_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. i_start performs the first
// iteration; o_done is high during the cycle whose closing edge performs the
// last iteration, so o_quotient holds the result from the following cycle on.
module seq_divider
  import tracking_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [SUM_W-1:0]   i_dividend,
  input  logic [CNT_W-1:0]   i_divisor,
  output logic [COORD_W-1:0] o_quotient,
  output logic               o_done
);

  localparam int ITER_W = $clog2(SUM_W);

  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              busy_q, busy_d;

  logic [SUM_W-1:0]  src_quo;
  logic [CNT_W-1:0]  src_rem;
  logic [CNT_W-1:0]  src_dvs;
  logic [CNT_W:0]    trial;
  logic              fits;
  logic [CNT_W-1:0]  step_rem;
  logic [SUM_W-1:0]  step_quo;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    src_quo  = i_start ? i_dividend : quo_q;
    src_rem  = i_start ? '0 : rem_q;
    src_dvs  = i_start ? i_divisor : dvs_q;
    trial    = {src_rem, src_quo[SUM_W-1]};
    fits     = (trial >= {1'b0, src_dvs});
    step_rem = fits ? (trial[CNT_W-1:0] - src_dvs) : trial[CNT_W-1:0];
    step_quo = {src_quo[SUM_W-2:0], fits};

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (i_start) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      dvs_d  = i_divisor;
      iter_d = ITER_W'(SUM_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      iter_d = iter_q - 1'b1;
      if (iter_q == ITER_W'(1)) busy_d = 1'b0;
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  assign o_done     = busy_q && (iter_q == ITER_W'(1));
  assign o_quotient = quo_q[COORD_W-1:0];

endmodule

// File: rtl/target_centroid_tracker.sv
// Per-frame red-target locator: accumulates matching pixel coordinates,
// divides at end of frame and emits the tracking sub-frame top-left corner.
module target_centroid_tracker
  import tracking_pkg::*;
#(
  parameter logic [9:0] R_MIN     = 10'd600,
  parameter logic [9:0] G_MAX     = 10'd300,
  parameter logic [9:0] B_MAX     = 10'd300,
  parameter int         MIN_COUNT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_pix_val,
  input  logic [9:0]   i_h,
  input  logic [9:0]   i_v,
  input  logic [29:0]  i_color,
  output logic [9:0]   o_pointH,
  output logic [9:0]   o_pointV,
  output logic         o_pointVAL,
  output logic         o_lost,
  output logic         o_overrun
);

  localparam logic signed [10:0] HALF_H = 11'(SUB_H / 2);
  localparam logic signed [10:0] HALF_V = 11'(SUB_V / 2);
  localparam logic signed [10:0] MAX_H  = 11'(FRAME_W - SUB_H);
  localparam logic signed [10:0] MAX_V  = 11'(FRAME_H - SUB_V);

  track_state_e     state_q, state_d;
  logic [SUM_W-1:0] sum_h_q, sum_h_d, sum_v_q, sum_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] snap_h_q, snap_h_d, snap_v_q, snap_v_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic             start_q, start_d;
  logic [9:0]       qh_q, qh_d;
  logic [9:0]       point_h_q, point_h_d, point_v_q, point_v_d;
  logic             point_val_q, point_val_d;
  logic             lost_q, lost_d;
  logic             overrun_q, overrun_d;

  logic             match, eof;
  logic [SUM_W-1:0] sum_h_inc, sum_v_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic signed [10:0] diff_h, diff_v;
  logic [9:0]       clamp_h, clamp_v;
  logic [SUM_W-1:0] div_dividend;
  logic [9:0]       div_quotient;
  logic             div_done;

  // The one shared divider handles H first, then V.
  seq_divider u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (start_q),
    .i_dividend (div_dividend),
    .i_divisor  (snap_cnt_q),
    .o_quotient (div_quotient),
    .o_done     (div_done)
  );

  assign div_dividend = (state_q == DIV_H) ? snap_h_q : snap_v_q;

  // Pixel classification and the accumulator values including this pixel.
  always_comb begin
    match = i_pix_val
         && (i_color[R_MSB:R_LSB] >= R_MIN)
         && (i_color[G_MSB:G_LSB] <= G_MAX)
         && (i_color[B_MSB:B_LSB] <= B_MAX);
    eof = i_pix_val && (i_h == 10'(FRAME_W - 1)) && (i_v == 10'(FRAME_H - 1));
    sum_h_inc = sum_h_q + (match ? SUM_W'(i_h) : '0);
    sum_v_inc = sum_v_q + (match ? SUM_W'(i_v) : '0);
    cnt_inc   = cnt_q + CNT_W'(match);
  end

  // Centre-to-corner offset, clamped so the box stays on screen.
  always_comb begin
    diff_h = $signed({1'b0, qh_q}) - HALF_H;
    diff_v = $signed({1'b0, div_quotient}) - HALF_V;
    if (diff_h < 0)          clamp_h = '0;
    else if (diff_h > MAX_H) clamp_h = MAX_H[9:0];
    else                     clamp_h = diff_h[9:0];
    if (diff_v < 0)          clamp_v = '0;
    else if (diff_v > MAX_V) clamp_v = MAX_V[9:0];
    else                     clamp_v = diff_v[9:0];
  end

  // Accumulation, end-of-frame snapshot and the divide/output sequence.
  always_comb begin
    state_d     = state_q;
    sum_h_d     = sum_h_inc;
    sum_v_d     = sum_v_inc;
    cnt_d       = cnt_inc;
    snap_h_d    = snap_h_q;
    snap_v_d    = snap_v_q;
    snap_cnt_d  = snap_cnt_q;
    start_d     = 1'b0;
    qh_d        = qh_q;
    point_h_d   = point_h_q;
    point_v_d   = point_v_q;
    point_val_d = 1'b0;
    lost_d      = 1'b0;
    overrun_d   = 1'b0;

    if (eof) begin
      sum_h_d = '0;
      sum_v_d = '0;
      cnt_d   = '0;
      if (state_q == ACCUM) begin
        if (cnt_inc < CNT_W'(MIN_COUNT)) begin
          lost_d = 1'b1;
        end else begin
          snap_h_d   = sum_h_inc;
          snap_v_d   = sum_v_inc;
          snap_cnt_d = cnt_inc;
          start_d    = 1'b1;
          state_d    = DIV_H;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      DIV_H: begin
        if (div_done) begin
          state_d = DIV_V;
          start_d = 1'b1;
        end
      end
      DIV_V: begin
        if (start_q) qh_d = div_quotient;
        if (div_done) state_d = OUT;
      end
      OUT: begin
        point_h_d   = clamp_h;
        point_v_d   = clamp_v;
        point_val_d = 1'b1;
        state_d     = ACCUM;
      end
      default: ;
    endcase
  end

  // State registers; reset parks the outputs off-screen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ACCUM;
      sum_h_q     <= '0;
      sum_v_q     <= '0;
      cnt_q       <= '0;
      snap_h_q    <= '0;
      snap_v_q    <= '0;
      snap_cnt_q  <= '0;
      start_q     <= 1'b0;
      qh_q        <= '0;
      point_h_q   <= 10'h3FF;
      point_v_q   <= 10'h3FF;
      point_val_q <= 1'b0;
      lost_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_h_q     <= sum_h_d;
      sum_v_q     <= sum_v_d;
      cnt_q       <= cnt_d;
      snap_h_q    <= snap_h_d;
      snap_v_q    <= snap_v_d;
      snap_cnt_q  <= snap_cnt_d;
      start_q     <= start_d;
      qh_q        <= qh_d;
      point_h_q   <= point_h_d;
      point_v_q   <= point_v_d;
      point_val_q <= point_val_d;
      lost_q      <= lost_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_pointH   = point_h_q;
  assign o_pointV   = point_v_q;
  assign o_pointVAL = point_val_q;
  assign o_lost     = lost_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_target_centroid_tracker.sv
// Directed self-checking bench for target_centroid_tracker.
module tb_target_centroid_tracker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pix_val;
  logic [9:0]  i_h;
  logic [9:0]  i_v;
  logic [29:0] i_color;
  logic [9:0]  o_pointH;
  logic [9:0]  o_pointV;
  logic        o_pointVAL;
  logic        o_lost;
  logic        o_overrun;

  localparam logic [29:0] RED   = {10'd700, 10'd100, 10'd100};
  localparam logic [29:0] BLACK = 30'd0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int val_n = 0, lost_n = 0, ovr_n = 0, both_n = 0;
  int val_cycle = 0, lost_cycle = 0, ovr_cycle = 0;
  int eof_cyc = 0;

  target_centroid_tracker dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pix_val  (i_pix_val),
    .i_h        (i_h),
    .i_v        (i_v),
    .i_color    (i_color),
    .o_pointH   (o_pointH),
    .o_pointV   (o_pointV),
    .o_pointVAL (o_pointVAL),
    .o_lost     (o_lost),
    .o_overrun  (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Edge counter: a pixel sampled at edge E lives in cycle E.
  always @(posedge i_clk) cyc++;

  // Strobe monitor; a strobe seen after edge E lives in cycle E+1.
  always @(negedge i_clk) begin
    if (o_pointVAL) begin val_n++; val_cycle = cyc + 1; end
    if (o_lost) begin lost_n++; lost_cycle = cyc + 1; end
    if (o_overrun) begin ovr_n++; ovr_cycle = cyc + 1; end
    if (o_pointVAL && o_lost) both_n++;
  end

  task automatic pix(input logic val, input logic [9:0] h, input logic [9:0] v,
                     input logic [29:0] c);
    i_pix_val = val;
    i_h       = h;
    i_v       = v;
    i_color   = c;
    @(posedge i_clk);
    #1;
    eof_cyc   = cyc;
    i_pix_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic block(input int h0, input int v0, input int w, input int hgt);
    for (int y = v0; y < v0 + hgt; y++)
      for (int x = h0; x < h0 + w; x++)
        pix(1'b1, 10'(x), 10'(y), RED);
  endtask

  task automatic wait_val(input int base, input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(posedge i_clk);
      #1;
      if (val_n > base) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    idle(3);
    checks++; if (o_pointH !== 10'h3FF) begin errors++; $display("[TB] FAIL reset_pointH got %h want 3ff", o_pointH); end
    checks++; if (o_pointV !== 10'h3FF) begin errors++; $display("[TB] FAIL reset_pointV got %h want 3ff", o_pointV); end
    checks++; if (o_pointVAL !== 1'b0) begin errors++; $display("[TB] FAIL reset_pointVAL got %b want 0", o_pointVAL); end
    checks++; if (o_lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost got %b want 0", o_lost); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", o_overrun); end
    i_rst = 1'b0;
    idle(2);
  endtask

  // 8 pixels exactly on the colour thresholds, 9 just outside them.
  task automatic test_lost;
    int vb, lb;
    vb = val_n;
    lb = lost_n;
    for (int k = 0; k < 8; k++) pix(1'b1, 10'(10 + k), 10'd10, {10'd600, 10'd300, 10'd300});
    for (int k = 0; k < 3; k++) pix(1'b1, 10'(20 + k), 10'd10, {10'd599, 10'd0, 10'd0});
    for (int k = 0; k < 3; k++) pix(1'b1, 10'(30 + k), 10'd10, {10'd700, 10'd301, 10'd0});
    for (int k = 0; k < 3; k++) pix(1'b1, 10'(40 + k), 10'd10, {10'd700, 10'd0, 10'd301});
    pix(1'b1, 10'd639, 10'd479, BLACK);
    idle(70);
    checks++; if (lost_n - lb !== 1) begin errors++; $display("[TB] FAIL lost_pulses got %0d want 1", lost_n - lb); end
    checks++; if (lost_cycle - eof_cyc !== 1) begin errors++; $display("[TB] FAIL lost_latency got %0d want 1", lost_cycle - eof_cyc); end
    checks++; if (val_n - vb !== 0) begin errors++; $display("[TB] FAIL lost_no_val got %0d want 0", val_n - vb); end
    checks++; if (o_pointH !== 10'h3FF) begin errors++; $display("[TB] FAIL lost_hold_H got %h want 3ff", o_pointH); end
    checks++; if (o_pointV !== 10'h3FF) begin errors++; $display("[TB] FAIL lost_hold_V got %h want 3ff", o_pointV); end
  endtask

  // 10x10 at h 100..109, v 50..59: centroid (104,54) -> (72,30).
  task automatic test_centroid;
    int vb, lb;
    bit seen;
    vb = val_n;
    lb = lost_n;
    block(100, 50, 10, 10);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL centroid_timeout got none want pointVAL"); end
    checks++; if (val_cycle - eof_cyc !== 58) begin errors++; $display("[TB] FAIL centroid_latency got %0d want 58", val_cycle - eof_cyc); end
    checks++; if (o_pointH !== 10'd72) begin errors++; $display("[TB] FAIL centroid_H got %0d want 72", o_pointH); end
    checks++; if (o_pointV !== 10'd30) begin errors++; $display("[TB] FAIL centroid_V got %0d want 30", o_pointV); end
    checks++; if (o_pointVAL !== 1'b0) begin errors++; $display("[TB] FAIL centroid_pulse_width got %b want 0", o_pointVAL); end
    idle(5);
    checks++; if (val_n - vb !== 1) begin errors++; $display("[TB] FAIL centroid_val_count got %0d want 1", val_n - vb); end
    checks++; if (lost_n - lb !== 0) begin errors++; $display("[TB] FAIL centroid_no_lost got %0d want 0", lost_n - lb); end
  endtask

  // Bottom-right corner block clamps to (576,432); top-left to (0,0).
  task automatic test_clamp;
    int vb;
    bit seen;
    vb = val_n;
    block(636, 476, 4, 4);
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL clamp_hi_timeout got none want pointVAL"); end
    checks++; if (val_cycle - eof_cyc !== 58) begin errors++; $display("[TB] FAIL clamp_hi_latency got %0d want 58", val_cycle - eof_cyc); end
    checks++; if (o_pointH !== 10'd576) begin errors++; $display("[TB] FAIL clamp_hi_H got %0d want 576", o_pointH); end
    checks++; if (o_pointV !== 10'd432) begin errors++; $display("[TB] FAIL clamp_hi_V got %0d want 432", o_pointV); end
    idle(3);
    vb = val_n;
    block(0, 0, 4, 4);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL clamp_lo_timeout got none want pointVAL"); end
    checks++; if (o_pointH !== 10'd0) begin errors++; $display("[TB] FAIL clamp_lo_H got %0d want 0", o_pointH); end
    checks++; if (o_pointV !== 10'd0) begin errors++; $display("[TB] FAIL clamp_lo_V got %0d want 0", o_pointV); end
    idle(3);
  endtask

  // Matching colour with i_pix_val low, EOF coordinates included; one real match.
  task automatic test_invalid_ignored;
    int vb, lb;
    vb = val_n;
    lb = lost_n;
    for (int k = 0; k < 200; k++) begin
      if (k % 50 == 0) pix(1'b0, 10'd639, 10'd479, RED);
      else pix(1'b0, 10'((k * 7) % 640), 10'((k * 3) % 480), RED);
    end
    pix(1'b1, 10'd5, 10'd5, RED);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    idle(70);
    checks++; if (lost_n - lb !== 1) begin errors++; $display("[TB] FAIL invalid_lost_pulses got %0d want 1", lost_n - lb); end
    checks++; if (lost_cycle - eof_cyc !== 1) begin errors++; $display("[TB] FAIL invalid_lost_latency got %0d want 1", lost_cycle - eof_cyc); end
    checks++; if (val_n - vb !== 0) begin errors++; $display("[TB] FAIL invalid_no_val got %0d want 0", val_n - vb); end
    checks++; if (o_pointH !== 10'd0 || o_pointV !== 10'd0) begin errors++; $display("[TB] FAIL invalid_hold got %0d,%0d want 0,0", o_pointH, o_pointV); end
  endtask

  // Second EOF 20 cycles after the first is dropped with o_overrun.
  task automatic test_back_to_back;
    int vb, ob, lb, eof_a, eof_b;
    bit seen;
    vb = val_n;
    ob = ovr_n;
    lb = lost_n;
    block(100, 50, 10, 10);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    eof_a = eof_cyc;
    block(200, 100, 4, 4);
    idle(3);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    eof_b = eof_cyc;
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_first_timeout got none want pointVAL"); end
    checks++; if (val_cycle - eof_a !== 58) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 58", val_cycle - eof_a); end
    checks++; if (o_pointH !== 10'd72 || o_pointV !== 10'd30) begin errors++; $display("[TB] FAIL b2b_first_point got %0d,%0d want 72,30", o_pointH, o_pointV); end
    checks++; if (ovr_n - ob !== 1) begin errors++; $display("[TB] FAIL b2b_overrun_pulses got %0d want 1", ovr_n - ob); end
    checks++; if (ovr_cycle - eof_b !== 1) begin errors++; $display("[TB] FAIL b2b_overrun_latency got %0d want 1", ovr_cycle - eof_b); end
    idle(3);
    vb = val_n;
    // 4x4 at h 300..303, v 200..203: centroid (301,201) -> (269,177).
    block(300, 200, 4, 4);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_next_timeout got none want pointVAL"); end
    checks++; if (o_pointH !== 10'd269 || o_pointV !== 10'd177) begin errors++; $display("[TB] FAIL b2b_next_point got %0d,%0d want 269,177", o_pointH, o_pointV); end
    checks++; if (lost_n - lb !== 0) begin errors++; $display("[TB] FAIL b2b_no_lost got %0d want 0", lost_n - lb); end
    idle(3);
  endtask

  // Reset 30 cycles into a division aborts it; a clean frame then works.
  task automatic test_reset_mid_div;
    int vb;
    bit seen;
    vb = val_n;
    block(100, 50, 10, 10);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    idle(29);
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    checks++; if (o_pointH !== 10'h3FF || o_pointV !== 10'h3FF) begin errors++; $display("[TB] FAIL middiv_reset_point got %h,%h want 3ff,3ff", o_pointH, o_pointV); end
    idle(70);
    checks++; if (val_n - vb !== 0) begin errors++; $display("[TB] FAIL middiv_no_val got %0d want 0", val_n - vb); end
    vb = val_n;
    // 4x4 at h 200..203, v 100..103: centroid (201,101) -> (169,77).
    block(200, 100, 4, 4);
    pix(1'b1, 10'd639, 10'd479, BLACK);
    wait_val(vb, 80, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL middiv_clean_timeout got none want pointVAL"); end
    checks++; if (val_cycle - eof_cyc !== 58) begin errors++; $display("[TB] FAIL middiv_clean_latency got %0d want 58", val_cycle - eof_cyc); end
    checks++; if (o_pointH !== 10'd169 || o_pointV !== 10'd77) begin errors++; $display("[TB] FAIL middiv_clean_point got %0d,%0d want 169,77", o_pointH, o_pointV); end
    idle(3);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_pix_val = 1'b0;
    i_h       = '0;
    i_v       = '0;
    i_color   = '0;
    test_reset();
    test_lost();
    test_centroid();
    test_clamp();
    test_invalid_ignored();
    test_back_to_back();
    test_reset_mid_div();
    checks++; if (both_n !== 0) begin errors++; $display("[TB] FAIL lost_and_val_together got %0d want 0", both_n); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
